// File: rtl/i2s_multi_rx.sv
// Multi-lane I2S master receiver: bclk/wclk generation, per-lane capture, tagged FWFT output FIFO.
// Optional feature: define I2S_MULTI_RX_DROPCNT_EN to add the saturating drop_cnt[15:0] port.
module i2s_multi_rx #(
    parameter int unsigned LANES      = 4,
    parameter int unsigned SAMPLE_W   = 24,
    parameter int unsigned SLOT_W     = 32,
    parameter int unsigned BCLK_DIV   = 4,
    parameter int unsigned FIFO_DEPTH = 16,
    localparam int unsigned CH_W      = (LANES > 1) ? $clog2(2 * LANES) : 1
) (
    input  logic                adc_clk,
    input  logic                adc_clk_rst_n,
    input  logic                enable,
    input  logic [LANES-1:0]    din,
    output logic                i2s_bclk,
    output logic                i2s_wclk,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [SAMPLE_W-1:0] m_data,
    output logic [CH_W-1:0]     m_chan,
    output logic                overflow,
    input  logic                ovf_clr
`ifdef I2S_MULTI_RX_DROPCNT_EN
    ,
    output logic [15:0]         drop_cnt
`endif
);

    localparam int unsigned DIV_W  = $clog2(BCLK_DIV);
    localparam int unsigned HALF   = BCLK_DIV / 2;
    localparam int unsigned BIT_W  = $clog2(SLOT_W);
    localparam int unsigned LIDX_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned WORD_W = CH_W + SAMPLE_W;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_STOP} state_e;

    state_e             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [BIT_W-1:0]   bitcnt_q, bitcnt_d;
    logic               bclk_q, bclk_d;
    logic               wclk_q, wclk_d;

    logic               running, fall, rise, last_bit, slot_end_r;
    logic               cap, done_d, done_q;

    logic [SAMPLE_W-1:0] shift_q [LANES];
    logic [SAMPLE_W-1:0] hold_q  [LANES];
    logic                hold_r_q;
    logic                seq_act_q;
    logic [LIDX_W-1:0]   seq_idx_q;
    logic [CH_W-1:0]     push_chan;
    logic [WORD_W-1:0]   push_word;

    logic [WORD_W-1:0]   mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                pop, full, acc, drop;
    logic [WORD_W-1:0]   head;
    logic                valid_q, valid_d;
    logic [SAMPLE_W-1:0] data_q, data_d;
    logic [CH_W-1:0]     chan_q, chan_d;
    logic                ovf_q, ovf_d;

    assign running    = (state_q != S_IDLE);
    assign fall       = running && (div_q == DIV_W'(BCLK_DIV - 1));
    assign rise       = running && (div_q == DIV_W'(HALF));
    assign last_bit   = (bitcnt_q == BIT_W'(SLOT_W - 1));
    assign slot_end_r = fall && last_bit && wclk_q;

    always_ff @(posedge adc_clk or negedge adc_clk_rst_n) begin
        if (!adc_clk_rst_n) state_q <= S_IDLE;
        else                state_q <= state_d;
    end

    // A stop request is latched in S_STOP so the right slot always finishes.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (enable) state_d = S_RUN;
            S_RUN:  if (!enable) state_d = slot_end_r ? S_IDLE : S_STOP;
            S_STOP: if (slot_end_r) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        div_d    = div_q;
        bitcnt_d = bitcnt_q;
        wclk_d   = wclk_q;
        if (state_d == S_IDLE) begin
            div_d    = '0;
            bitcnt_d = '0;
            wclk_d   = 1'b0;
        end else if (running) begin
            if (fall) begin
                div_d    = '0;
                bitcnt_d = last_bit ? '0 : bitcnt_q + 1'b1;
                if (last_bit) wclk_d = ~wclk_q;
            end else begin
                div_d = div_q + 1'b1;
            end
        end
        bclk_d = (state_d != S_IDLE) && (div_d >= DIV_W'(HALF));
    end

    always_ff @(posedge adc_clk or negedge adc_clk_rst_n) begin
        if (!adc_clk_rst_n) begin
            div_q    <= '0;
            bitcnt_q <= '0;
            bclk_q   <= 1'b0;
            wclk_q   <= 1'b0;
        end else begin
            div_q    <= div_d;
            bitcnt_q <= bitcnt_d;
            bclk_q   <= bclk_d;
            wclk_q   <= wclk_d;
        end
    end

    // One-bit I2S delay: slot bit 0 is skipped, data occupies bits 1..SAMPLE_W.
    assign cap    = rise && (bitcnt_q != '0) && (bitcnt_q <= BIT_W'(SAMPLE_W));
    assign done_d = rise && (bitcnt_q == BIT_W'(SAMPLE_W));

    always_ff @(posedge adc_clk or negedge adc_clk_rst_n) begin
        if (!adc_clk_rst_n) begin
            for (int unsigned k = 0; k < LANES; k++) shift_q[k] <= '0;
        end else if (cap) begin
            for (int unsigned k = 0; k < LANES; k++) shift_q[k] <= SAMPLE_W'({shift_q[k], din[k]});
        end
    end

    // The push sequencer runs independently of the generator state, so a pending
    // sequence still completes after the stop wrap.
    always_ff @(posedge adc_clk or negedge adc_clk_rst_n) begin
        if (!adc_clk_rst_n) begin
            done_q    <= 1'b0;
            hold_r_q  <= 1'b0;
            seq_act_q <= 1'b0;
            seq_idx_q <= '0;
            for (int unsigned k = 0; k < LANES; k++) hold_q[k] <= '0;
        end else begin
            done_q <= done_d;
            if (done_q) begin
                hold_q    <= shift_q;
                hold_r_q  <= wclk_q;
                seq_act_q <= 1'b1;
                seq_idx_q <= '0;
            end else if (seq_act_q) begin
                seq_idx_q <= seq_idx_q + 1'b1;
                if (seq_idx_q == LIDX_W'(LANES - 1)) seq_act_q <= 1'b0;
            end
        end
    end

    assign push_chan = CH_W'({seq_idx_q, 1'b0}) | CH_W'(hold_r_q);
    assign push_word = {push_chan, hold_q[seq_idx_q]};

    always_comb begin
        pop  = valid_q & m_ready;
        full = (cnt_q == CNT_W'(FIFO_DEPTH));
        acc  = seq_act_q & (~full | pop);
        drop = seq_act_q & full & ~pop;
        rd_d = pop ? rd_q + 1'b1 : rd_q;
        wr_d = acc ? wr_q + 1'b1 : wr_q;
        cnt_d = cnt_q;
        if (acc && !pop)      cnt_d = cnt_q + 1'b1;
        else if (!acc && pop) cnt_d = cnt_q - 1'b1;
        // The head bypasses storage when the word being written becomes the new head.
        head    = (acc && (wr_q == rd_d)) ? push_word : mem_q[rd_d];
        valid_d = (cnt_d != '0);
        chan_d  = chan_q;
        data_d  = data_q;
        if (valid_d) {chan_d, data_d} = head;
        ovf_d = ovf_q;
        if (drop)         ovf_d = 1'b1;
        else if (ovf_clr) ovf_d = 1'b0;
    end

    always_ff @(posedge adc_clk) begin
        if (acc) mem_q[wr_q] <= push_word;
    end

    always_ff @(posedge adc_clk or negedge adc_clk_rst_n) begin
        if (!adc_clk_rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            chan_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            chan_q  <= chan_d;
            ovf_q   <= ovf_d;
        end
    end

`ifdef I2S_MULTI_RX_DROPCNT_EN
    logic [15:0] dcnt_q, dcnt_d;

    always_comb begin
        dcnt_d = dcnt_q;
        if (drop)         dcnt_d = ovf_clr ? 16'd1 : ((dcnt_q == '1) ? dcnt_q : dcnt_q + 1'b1);
        else if (ovf_clr) dcnt_d = '0;
    end

    always_ff @(posedge adc_clk or negedge adc_clk_rst_n) begin
        if (!adc_clk_rst_n) dcnt_q <= '0;
        else                dcnt_q <= dcnt_d;
    end

    assign drop_cnt = dcnt_q;
`endif

    assign i2s_bclk = bclk_q;
    assign i2s_wclk = wclk_q;
    assign m_valid  = valid_q;
    assign m_data   = data_q;
    assign m_chan   = chan_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_i2s_multi_rx.sv
// Directed bench for i2s_multi_rx: table of per-lane words/expected stream plus multi-cycle sequences.
// An ADC model drives din from the DUT's bclk/wclk; a monitor checks popped words against a queue.
module tb_i2s_multi_rx;

    localparam int unsigned LANES = 4;
    localparam int unsigned SW    = 24;

    logic              adc_clk = 1'b0;
    logic              rst_n;
    logic              enable;
    logic [LANES-1:0]  din;
    logic              i2s_bclk, i2s_wclk;
    logic              m_valid, m_ready;
    logic [SW-1:0]     m_data;
    logic [2:0]        m_chan;
    logic              overflow, ovf_clr;
`ifdef I2S_MULTI_RX_DROPCNT_EN
    logic [15:0]       drop_cnt;
`endif

    i2s_multi_rx #(
        .LANES(4), .SAMPLE_W(24), .SLOT_W(32), .BCLK_DIV(4), .FIFO_DEPTH(8)
    ) dut (
        .adc_clk(adc_clk), .adc_clk_rst_n(rst_n), .enable(enable), .din(din),
        .i2s_bclk(i2s_bclk), .i2s_wclk(i2s_wclk), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_chan(m_chan), .overflow(overflow), .ovf_clr(ovf_clr)
`ifdef I2S_MULTI_RX_DROPCNT_EN
        , .drop_cnt(drop_cnt)
`endif
    );

    always #5 adc_clk = ~adc_clk;

    typedef struct {
        int unsigned lane;
        bit          right;
        logic [23:0] din_word;
        logic [2:0]  exp_chan;
        logic [23:0] exp_data;
    } vec_t;

    vec_t        vecs [8];
    logic [23:0] adc_word [2][LANES];
    logic [26:0] exp_q [$];
    logic [26:0] mon_e;
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    task automatic push_slot(input bit right);
        for (int i = 0; i < 8; i++)
            if (vecs[i].right == right) exp_q.push_back({vecs[i].exp_chan, vecs[i].exp_data});
    endtask

    // ADC model: changes data after each bclk fall, one bit after the wclk edge, MSB first.
    int unsigned adc_bit;
    logic        prev_bclk, prev_wclk;
    always @(negedge adc_clk) begin
        if (!rst_n) begin
            adc_bit   = 0;
            prev_bclk = 1'b0;
            prev_wclk = 1'b0;
            din       = '0;
        end else begin
            if (prev_bclk && !i2s_bclk) begin
                if (i2s_wclk != prev_wclk) adc_bit = 0;
                else                       adc_bit++;
                prev_wclk = i2s_wclk;
                for (int k = 0; k < LANES; k++)
                    din[k] = (adc_bit >= 1 && adc_bit <= SW) ? adc_word[i2s_wclk][k][SW - adc_bit] : 1'b0;
            end
            prev_bclk = i2s_bclk;
        end
    end

    always @(negedge adc_clk) begin
        #2;
        if (rst_n && m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got chan %0d data %h, expected no word", m_chan, m_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("word_chan", 32'(m_chan), 32'(mon_e[26:24]));
                check("word_data", 32'(m_data), 32'(mon_e[23:0]));
            end
        end
    end

    task automatic run_session(input string tag, input int ready_at, input bit ovf_phase, input bit full_phase);
        logic [7:0]  bpat = '0;
        int          first_rise = -1, wrise = -1, wfall = -1, first_valid = -1, last_active = -1;
        int unsigned highs = 0;
        enable = 1'b1;
        @(posedge adc_clk);
        for (int i = 0; i < 700; i++) begin
            @(negedge adc_clk);
            if (i == 0) check({tag, "_start_wclk"}, 32'(i2s_wclk), 0);
            if (i < 8) bpat[i] = i2s_bclk;
            if (first_rise < 0 && i2s_bclk) first_rise = i;
            if (i < 256 && i2s_bclk) highs++;
            if (wrise < 0 && i2s_wclk) wrise = i;
            if (wrise >= 0 && wfall < 0 && !i2s_wclk) wfall = i;
            if (first_valid < 0 && m_valid) first_valid = i;
            if (i2s_bclk || i2s_wclk) last_active = i;
            if (i == 260) enable = 1'b0;
            if (i == ready_at) m_ready = 1'b1;
            if (ovf_phase && i == 400) begin
                check({tag, "_overflow_set"}, 32'(overflow), 1);
`ifdef I2S_MULTI_RX_DROPCNT_EN
                check({tag, "_drop_cnt"}, 32'(drop_cnt), 4);
`endif
                check({tag, "_held_valid"}, 32'(m_valid), 1);
                check({tag, "_held_chan"}, 32'(m_chan), 0);
                check({tag, "_held_data"}, 32'(m_data), 32'hA00000);
                ovf_clr = 1'b1;
            end
            if (ovf_phase && i == 401) ovf_clr = 1'b0;
            if (ovf_phase && i == 403) begin
                check({tag, "_overflow_clr"}, 32'(overflow), 0);
`ifdef I2S_MULTI_RX_DROPCNT_EN
                check({tag, "_drop_cnt_clr"}, 32'(drop_cnt), 0);
`endif
            end
            if (full_phase && i == 360) check({tag, "_full_push_pop_ovf"}, 32'(overflow), 0);
        end
        check({tag, "_bclk_pattern"}, 32'(bpat), 32'hCC);
        check({tag, "_first_rise"}, 32'(first_rise), 2);
        check({tag, "_bclk_duty"}, highs, 128);
        check({tag, "_wclk_rise"}, 32'(wrise), 128);
        check({tag, "_wclk_fall"}, 32'(wfall), 256);
        check({tag, "_first_valid"}, 32'(first_valid), 101);
        check({tag, "_last_active"}, 32'(last_active), 511);
        check({tag, "_queue_drained"}, 32'(exp_q.size()), 0);
        check({tag, "_end_valid"}, 32'(m_valid), 0);
    endtask

    initial begin
        vecs[0] = '{lane: 0, right: 1'b0, din_word: 24'hA00000, exp_chan: 3'd0, exp_data: 24'hA00000};
        vecs[1] = '{lane: 1, right: 1'b0, din_word: 24'hA00001, exp_chan: 3'd2, exp_data: 24'hA00001};
        vecs[2] = '{lane: 2, right: 1'b0, din_word: 24'hA00002, exp_chan: 3'd4, exp_data: 24'hA00002};
        vecs[3] = '{lane: 3, right: 1'b0, din_word: 24'hA00003, exp_chan: 3'd6, exp_data: 24'hA00003};
        vecs[4] = '{lane: 0, right: 1'b1, din_word: 24'h500000, exp_chan: 3'd1, exp_data: 24'h500000};
        vecs[5] = '{lane: 1, right: 1'b1, din_word: 24'h500001, exp_chan: 3'd3, exp_data: 24'h500001};
        vecs[6] = '{lane: 2, right: 1'b1, din_word: 24'h500002, exp_chan: 3'd5, exp_data: 24'h500002};
        vecs[7] = '{lane: 3, right: 1'b1, din_word: 24'h500003, exp_chan: 3'd7, exp_data: 24'h500003};
        for (int i = 0; i < 8; i++) adc_word[vecs[i].right][vecs[i].lane] = vecs[i].din_word;

        rst_n = 1'b0; enable = 1'b0; m_ready = 1'b1; ovf_clr = 1'b0;
        repeat (3) @(negedge adc_clk);
        check("rst_bclk", 32'(i2s_bclk), 0);
        check("rst_wclk", 32'(i2s_wclk), 0);
        check("rst_valid", 32'(m_valid), 0);
        check("rst_data", 32'(m_data), 0);
        check("rst_chan", 32'(m_chan), 0);
        check("rst_overflow", 32'(overflow), 0);
`ifdef I2S_MULTI_RX_DROPCNT_EN
        check("rst_drop_cnt", 32'(drop_cnt), 0);
`endif
        rst_n = 1'b1;
        repeat (2) @(negedge adc_clk);

        // Streaming with m_ready high; stop requested in the second left slot.
        push_slot(0); push_slot(1); push_slot(0); push_slot(1);
        run_session("stream", -1, 1'b0, 1'b0);

        // Three slots unconsumed into an 8-deep FIFO: second-frame left words drop.
        m_ready = 1'b0;
        push_slot(0); push_slot(1); push_slot(1);
        run_session("ovf", 405, 1'b1, 1'b0);

        // FIFO full while the consumer pops during each push of the third slot.
        m_ready = 1'b0;
        push_slot(0); push_slot(1); push_slot(0); push_slot(1);
        run_session("fullpp", 356, 1'b0, 1'b1);
        check("fullpp_end_ovf", 32'(overflow), 0);

        // Reset after lanes 0 and 1 of the first slot are written.
        m_ready = 1'b0;
        enable  = 1'b1;
        @(posedge adc_clk);
        for (int i = 0; i <= 102; i++) @(negedge adc_clk);
        check("pre_rst_valid", 32'(m_valid), 1);
        check("pre_rst_bclk", 32'(i2s_bclk), 1);
        rst_n = 1'b0;
        #1;
        check("midrst_bclk", 32'(i2s_bclk), 0);
        check("midrst_wclk", 32'(i2s_wclk), 0);
        check("midrst_valid", 32'(m_valid), 0);
        check("midrst_data", 32'(m_data), 0);
        check("midrst_chan", 32'(m_chan), 0);
        check("midrst_overflow", 32'(overflow), 0);
        enable = 1'b0;
        repeat (3) @(negedge adc_clk);
        rst_n   = 1'b1;
        m_ready = 1'b1;
        push_slot(0); push_slot(1);
        @(negedge adc_clk);
        enable = 1'b1;
        @(posedge adc_clk);
        begin
            int fv = -1;
            for (int i = 0; i < 300; i++) begin
                @(negedge adc_clk);
                if (i == 50) enable = 1'b0;
                if (fv < 0 && m_valid) fv = i;
            end
            check("postrst_first_valid", 32'(fv), 101);
        end
        check("postrst_queue_drained", 32'(exp_q.size()), 0);
        check("postrst_idle_bclk", 32'(i2s_bclk), 0);
        check("postrst_idle_wclk", 32'(i2s_wclk), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2s_multi_rx.md
# i2s_multi_rx

Parametrised multi-lane I2S master receiver running in the `adc_clk` domain. It generates the shared bit clock and word clock for up to `LANES` stereo ADC data lines, deserialises every lane, and delivers the samples as one tagged word stream through a first-word-fall-through FIFO with a valid/ready handshake. It sits between the ADC pins and the host-side capture/DPI logic, and replaces the separate per-lane clock-core and data-capture instances.

## Interface
- `LANES`, 4: number of `din` lines; each line carries two channels. Range 1..8.
- `SAMPLE_W`, 24: bits captured per slot, MSB first.
- `SLOT_W`, 32: bclk periods per slot. Must satisfy `SLOT_W >= SAMPLE_W+1`.
- `BCLK_DIV`, 4: adc_clk cycles per bclk period. Even, `>= 2`.
- `FIFO_DEPTH`, 16: output FIFO entries. Power of two, `>= 2*LANES`.

Ports (`CH_W = max(1, clog2(2*LANES))`):
- `adc_clk` in 1: sole clock.
- `adc_clk_rst_n` in 1: asynchronous, active-low reset.
- `enable` in 1: run request.
- `din` in LANES: serial data; bit k is lane k.
- `i2s_bclk` out 1: bit clock.
- `i2s_wclk` out 1: word clock; 0 = left, 1 = right.
- `m_valid` out 1: FIFO head valid.
- `m_ready` in 1: consumer accepts the head.
- `m_data` out SAMPLE_W: sample.
- `m_chan` out CH_W: channel index = 2*lane + (right ? 1 : 0).
- `overflow` out 1: sticky; a word was dropped.
- `ovf_clr` in 1: synchronous clear of `overflow` (and `drop_cnt`).
- `drop_cnt` out 16: present only with the macro; see Configuration.

## Operation
- Generator states:
  - IDLE: `i2s_bclk` = 0, `i2s_wclk` = 0, counters are zero. Goes to RUN when `enable` = 1.
  - RUN: the divider counts 0..BCLK_DIV-1. `i2s_bclk` is 0 for counts 0..BCLK_DIV/2-1 and 1 for the rest.
  - Falling edge of bclk: the divider wraps and `bit_cnt` advances 0..SLOT_W-1. On wrap to 0, `i2s_wclk` toggles.
  - Rising edge of bclk: the divider reaches BCLK_DIV/2.
- Capture:
  - Standard I2S with a one-bit delay. On the rising edge with `bit_cnt` in 1..SAMPLE_W, each lane shifts `din[k]` into its shift register, MSB first.
  - Bits at `bit_cnt` 0 and above SAMPLE_W are ignored.
- Slot completion, at the rising edge with `bit_cnt == SAMPLE_W`:
  - Next cycle, all lane shift registers copy to holding registers, tagged with the current `i2s_wclk`.
  - The push sequencer then writes lane 0..LANES-1 into the FIFO, one per cycle, over LANES consecutive cycles.
- FIFO:
  - A push while full drops that word and sets `overflow`. Remaining lanes still attempt to push.
  - Push and pop in the same cycle while full: the pop frees an entry and the push is accepted.
  - Push and pop in the same cycle while empty: the word is stored and `m_valid` rises next cycle.
- Stop: when `enable` = 0 is sampled, RUN continues to the end of the current right slot, i.e. `bit_cnt` wraps with `wclk` = 1. The pending push sequence completes, then the generator enters IDLE. The FIFO keeps draining in IDLE.
- `ovf_clr` and a drop in the same cycle: the drop wins, so `overflow` stays 1.
- Reset at any time clears everything immediately. Partial words and FIFO contents are discarded.

## Timing
- Reset values: `i2s_bclk` 0, `i2s_wclk` 0, `m_valid` 0, `m_data` 0, `m_chan` 0, `overflow` 0, `drop_cnt` 0, FIFO empty, state IDLE.
- First bclk rising edge: BCLK_DIV/2 cycles after the cycle in which RUN is entered.
- Push timing: with the last bit sampled in cycle N, holding registers load at N+1 and lane k pushes at N+2+k. With the FIFO empty and `m_ready` = 0, `m_valid` is 1 from cycle N+3.
- Outputs: all are registered. `m_data`/`m_chan` hold steady while `m_valid` = 1 and `m_ready` = 0. A pop occurs on `m_valid & m_ready`.
- Frame length: 2·SLOT_W·BCLK_DIV adc_clk cycles. The push sequence (LANES+1 cycles) always fits within one slot.

## Configuration
- `I2S_MULTI_RX_DROPCNT_EN` defined:
  - Port `drop_cnt[15:0]` exists.
  - It increments on every dropped word and saturates at 0xFFFF.
  - `ovf_clr` clears it to 0.
- Macro undefined: port `drop_cnt` is absent. Only the sticky `overflow` flag reports drops.

## Test plan
- LANES=4, SAMPLE_W=24, SLOT_W=32, BCLK_DIV=4, `m_ready`=1. Lane k drives 0xA00000+k on left and 0x500000+k on right. Expect per frame, in order: chan 0,2,4,6 carrying 0xA00000..0xA00003, then chan 1,3,5,7 carrying 0x500000..0x500003.
- Clock check after `enable`: bclk period is 4 cycles with 50% duty; wclk toggles every 128 cycles; the first rising edge is 2 cycles after RUN; the MSB is taken on the second rising edge after each wclk edge.
- `m_ready`=0 for 3 slots with FIFO_DEPTH=8 and LANES=4: expect 8 words stored, 4 dropped, `overflow`=1, `drop_cnt`=4 (macro on). Then `ovf_clr` pulses: both return to 0 and the 8 stored words drain in order.
- Drop `enable` during a left slot: the right slot still completes and its 4 words arrive; afterwards `bclk` and `wclk` stay 0; re-asserting `enable` restarts with `wclk`=0 and `bit_cnt`=0.
- `adc_clk_rst_n` asserted mid-push with 2 lanes already written: all outputs return to reset values the same cycle. After release and re-enable, the first word is chan 0 of a fresh slot.
- Hold the FIFO full while `m_ready`=1 coincides with a push: no drop and `overflow` stays 0.
